// File: rtl/inst_encoder.sv
// inst_encoder: packs a field bundle (opcode, rd, rs1, rs2, funct3, funct7,
// imm) into a 32-bit RV32I instruction word, flags bundles that cannot be
// encoded (emitting a NOP for them), and buffers results through a 2-entry
// skid (output register + skid register) so in_ready comes from a flop.
//
// Ports:
//   clk, reset              single clock, synchronous active-high reset
//   in_valid / in_ready     input handshake for the field bundle
//   in_opcode .. in_imm     instruction fields; in_imm is a full signed value
//   out_valid / out_ready   output handshake
//   out_inst, out_err       encoded word and "not encodable" flag
//   enc_count, err_count    saturating counts of drained good / bad words
module inst_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [6:0]  OP_R     = 7'b0110011;
  localparam logic [6:0]  OP_S     = 7'b0100011;
  localparam logic [6:0]  OP_IL    = 7'b0000011;
  localparam logic [6:0]  OP_I     = 7'b0010011;
  localparam logic [6:0]  OP_B     = 7'b1100011;
  localparam logic [6:0]  OP_LUI   = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC = 7'b0010111;
  localparam logic [31:0] NOP      = 32'h00000013;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic signed [31:0] imm_s;
  logic               fits12;
  logic               fits13;
  logic [31:0]        inst_p0;
  logic               err_p0;

  logic               vld_p1;
  logic [31:0]        inst_p1;
  logic               err_p1;
  logic               skid_vld_p1;
  logic [31:0]        skid_inst_p1;
  logic               skid_err_p1;
  logic [CNT_W-1:0]   enc_cnt_q;
  logic [CNT_W-1:0]   err_cnt_q;

  logic accept;
  logic drain;
  logic out_free;

  // ---- stage p0: combinational encode of the presented bundle ----
  assign imm_s  = in_imm;
  assign fits12 = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
  assign fits13 = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4095);

  always_comb begin
    inst_p0 = NOP;
    err_p0  = 1'b0;
    case (in_opcode)
      OP_R: inst_p0 = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      OP_IL: begin
        inst_p0 = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        err_p0  = !fits12;
      end
      OP_I: begin
        inst_p0 = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        err_p0  = !fits12;
        // Shift-immediates carry funct7 in imm[11:5]; only SLLI/SRLI/SRAI forms are legal.
        if (in_funct3 == 3'b001 && in_imm[11:5] != 7'b0000000)
          err_p0 = 1'b1;
        if (in_funct3 == 3'b101 && in_imm[11:5] != 7'b0000000 && in_imm[11:5] != 7'b0100000)
          err_p0 = 1'b1;
      end
      OP_S: begin
        inst_p0 = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        err_p0  = !fits12;
      end
      OP_B: begin
        inst_p0 = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                   in_imm[4:1], in_imm[11], in_opcode};
        err_p0  = !fits13 || in_imm[0];
      end
      OP_LUI, OP_AUIPC: begin
        inst_p0 = {in_imm[31:12], in_rd, in_opcode};
        err_p0  = (in_imm[11:0] != 12'h000);
      end
      default: err_p0 = 1'b1;
    endcase
    if (err_p0)
      inst_p0 = NOP;
  end

  assign in_ready = ~skid_vld_p1;
  assign accept   = in_valid && in_ready;
  assign drain    = vld_p1 && out_ready;
  assign out_free = !vld_p1 || out_ready;

  // ---- stage p1: output register, skid register and statistics ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1      <= 1'b0;
      inst_p1     <= 32'h0;
      err_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      enc_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (drain) begin
        if (err_p1) err_cnt_q <= sat_inc(err_cnt_q);
        else        enc_cnt_q <= sat_inc(enc_cnt_q);
      end
      if (out_free) begin
        // The skid entry is older than anything on the input, so it goes first.
        if (skid_vld_p1) begin
          vld_p1      <= 1'b1;
          inst_p1     <= skid_inst_p1;
          err_p1      <= skid_err_p1;
          skid_vld_p1 <= 1'b0;
        end else if (accept) begin
          vld_p1  <= 1'b1;
          inst_p1 <= inst_p0;
          err_p1  <= err_p0;
        end else begin
          vld_p1 <= 1'b0;
        end
      end else if (accept) begin
        skid_vld_p1 <= 1'b1;
      end
    end
  end

  // Skid payload only matters while skid_vld_p1 is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (!out_free && accept) begin
      skid_inst_p1 <= inst_p0;
      skid_err_p1  <= err_p0;
    end
  end

  assign out_valid = vld_p1;
  assign out_inst  = inst_p1;
  assign out_err   = err_p1;
  assign enc_count = enc_cnt_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: encode vectors at full rate, error cases,
// backpressure through the skid, reset with skid full, and counter
// saturation on a second instance built with CNT_W=2.
module tb_inst_encoder;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic [15:0] enc_count, err_count;

  logic        in_ready2, out_valid2, out_err2;
  logic [31:0] out_inst2;
  logic [1:0]  enc_count2, err_count2;

  int checks = 0;
  int errors = 0;

  inst_encoder #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_err(out_err), .enc_count(enc_count), .err_count(err_count)
  );

  inst_encoder #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid2), .out_ready(out_ready), .out_inst(out_inst2),
    .out_err(out_err2), .enc_count(enc_count2), .err_count(err_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_inst;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic add(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [31:0] imm, input logic [31:0] ei, input logic ee);
    vec_t v;
    v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7;
    v.imm = imm; v.exp_inst = ei; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  task automatic put(input vec_t v);
    in_valid  = 1'b1;
    in_opcode = v.op;  in_rd = v.rd;  in_rs1 = v.rs1; in_rs2 = v.rs2;
    in_funct3 = v.f3;  in_funct7 = v.f7; in_imm = v.imm;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int good;
    int bad;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;

    // Vectors: opcode, rd, rs1, rs2, funct3, funct7, imm, expected word, expected err
    add(7'b0100011, 5'd9, 5'd2, 5'd5, 3'b010, 7'h55, 32'hFFFFFFFC, 32'hFE512E23, 1'b0); // sw
    add(7'b1100011, 5'd7, 5'd1, 5'd2, 3'b000, 7'h00, 32'd8,        32'h00208463, 1'b0); // beq +8
    add(7'b0110111, 5'd1, 5'd3, 5'd4, 3'b111, 7'h7F, 32'h12345000, 32'h123450B7, 1'b0); // lui
    add(7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'h00, 32'h0,        32'h002081B3, 1'b0); // add
    add(7'b0010011, 5'd1, 5'd0, 5'd9, 3'b000, 7'h11, 32'hFFFFFFFF, 32'hFFF00093, 1'b0); // addi -1
    add(7'b0000011, 5'd5, 5'd2, 5'd0, 3'b010, 7'h00, 32'd4,        32'h00412283, 1'b0); // lw
    add(7'b0010011, 5'd1, 5'd1, 5'd0, 3'b001, 7'h00, 32'd3,        32'h00309093, 1'b0); // slli 3
    add(7'b0010011, 5'd1, 5'd1, 5'd0, 3'b101, 7'h00, 32'h403,      32'h4030D093, 1'b0); // srai 3
    add(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd2048,     32'h00000013, 1'b1); // addi 2048
    add(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'h00, 32'd6,        32'h00208363, 1'b0); // beq +6
    add(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'h00, 32'd5,        32'h00000013, 1'b1); // odd offset
    add(7'b1111111, 5'd1, 5'd1, 5'd1, 3'b000, 7'h00, 32'd0,        32'h00000013, 1'b1); // bad opcode
    add(7'b0010011, 5'd1, 5'd1, 5'd0, 3'b101, 7'h00, 32'h203,      32'h00000013, 1'b1); // bad srai
    add(7'b0010011, 5'd1, 5'd1, 5'd0, 3'b001, 7'h00, 32'h023,      32'h00000013, 1'b1); // bad slli
    add(7'b0010111, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'h00001001, 32'h00000013, 1'b1); // auipc low bits
    add(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'hFFFFF800, 32'h80000093, 1'b0); // addi -2048
    add(7'b0100011, 5'd0, 5'd2, 5'd5, 3'b010, 7'h00, 32'd2048,     32'h00000013, 1'b1); // sw 2048
    add(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'h00, 32'd4096,     32'h00000013, 1'b1); // beq 4096
    add(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'h00, 32'hFFFFF000, 32'h80208063, 1'b0); // beq -4096

    // Reset state
    tick; tick;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    reset = 1'b0;
    tick;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_enc_count", {16'd0, enc_count}, 32'd0);
    check("rst_err_count", {16'd0, err_count}, 32'd0);

    // Full-rate stream, one bundle per cycle
    good = 0; bad = 0;
    foreach (vecs[i]) begin
      put(vecs[i]);
      tick;
      check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("vec%0d_inst", i), out_inst, vecs[i].exp_inst);
      check($sformatf("vec%0d_err", i), {31'd0, out_err}, {31'd0, vecs[i].exp_err});
      check($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      if (vecs[i].exp_err) bad++; else good++;
    end
    in_valid = 1'b0;
    tick;
    check("stream_idle_valid", {31'd0, out_valid}, 32'd0);
    check("stream_enc_count", {16'd0, enc_count}, good);
    check("stream_err_count", {16'd0, err_count}, bad);

    // Backpressure: A accepted, B parked in skid, C refused until drain
    out_ready = 1'b0;
    put(vecs[3]); tick;
    check("bp_a_out", out_inst, vecs[3].exp_inst);
    check("bp_a_ready", {31'd0, in_ready}, 32'd1);
    put(vecs[4]); tick;
    check("bp_b_ready", {31'd0, in_ready}, 32'd0);
    check("bp_b_hold", out_inst, vecs[3].exp_inst);
    put(vecs[5]); tick;
    check("bp_c_ready", {31'd0, in_ready}, 32'd0);
    check("bp_c_hold", out_inst, vecs[3].exp_inst);
    check("bp_c_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick;
    check("bp_rel_out_b", out_inst, vecs[4].exp_inst);
    check("bp_rel_ready", {31'd0, in_ready}, 32'd1);
    tick;
    check("bp_out_c", out_inst, vecs[5].exp_inst);
    check("bp_out_c_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    tick;
    check("bp_idle_valid", {31'd0, out_valid}, 32'd0);
    check("bp_enc_count", {16'd0, enc_count}, good + 3);
    check("bp_err_count", {16'd0, err_count}, bad);

    // Saturating counters on the CNT_W=2 instance
    check("sat_enc_count", {30'd0, enc_count2}, (good + 3 > 3) ? 3 : good + 3);
    check("sat_err_count", {30'd0, err_count2}, (bad > 3) ? 3 : bad);

    // Reset while the skid is full, with a bundle still offered
    out_ready = 1'b0;
    put(vecs[0]); tick;
    put(vecs[1]); tick;
    check("rs_skid_full", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    in_valid = 1'b0;
    check("rs_out_valid", {31'd0, out_valid}, 32'd0);
    check("rs_in_ready", {31'd0, in_ready}, 32'd1);
    check("rs_enc_count", {16'd0, enc_count}, 32'd0);
    check("rs_err_count", {16'd0, err_count}, 32'd0);
    out_ready = 1'b1;
    tick;
    check("rs_nothing_left", {31'd0, out_valid}, 32'd0);
    check("rs_out_inst", out_inst, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
